cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter in front of one shared memory port.
// Define ARB_DCACHE_PRIORITY_EN to make the D-cache win every simultaneous request.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int BLOCK_SIZE = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  input  logic [BLOCK_SIZE-1:0] ic_wr,
  input  logic                  ic_rw,
  input  logic                  ic_valid,
  output logic [BLOCK_SIZE-1:0] ic_rd,
  output logic                  ic_ready,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [BLOCK_SIZE-1:0] dc_wr,
  input  logic                  dc_rw,
  input  logic                  dc_valid,
  output logic [BLOCK_SIZE-1:0] dc_rd,
  output logic                  dc_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0] mem_wr,
  output logic                  mem_rw,
  output logic                  mem_valid_out,
  input  logic [BLOCK_SIZE-1:0] mem_rd,
  input  logic                  mem_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_last_grant;   // 1 = D-cache was granted last, 0 = I-cache
  logic [15:0] r_wait_cnt;     // observed through hierarchy only
  logic        w_pick_d;
  logic        w_grant_entry;

  always_comb begin
    w_state_next = r_state;
    w_pick_d     = 1'b0;
    case (r_state)
      IDLE: begin
`ifdef ARB_DCACHE_PRIORITY_EN
        w_pick_d = dc_valid;
`else
        w_pick_d = dc_valid && (!ic_valid || !r_last_grant);
`endif
        if (w_pick_d) begin
          w_state_next = GRANT_D;
        end else if (ic_valid) begin
          w_state_next = GRANT_I;
        end
      end
      // Dropping valid before mem_ready aborts the access.
      GRANT_I: begin
        if (!ic_valid || mem_ready) begin
          w_state_next = IDLE;
        end
      end
      GRANT_D: begin
        if (!dc_valid || mem_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_grant_entry = (r_state == IDLE) && (w_state_next != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b0;
      r_wait_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_entry) begin
        r_last_grant <= (w_state_next == GRANT_D);
        r_wait_cnt   <= 16'd0;
      end else if ((r_state != IDLE) && !mem_ready && (r_wait_cnt != 16'hFFFF)) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    mem_addr      = '0;
    mem_wr        = '0;
    mem_rw        = 1'b0;
    mem_valid_out = 1'b0;
    ic_rd         = '0;
    ic_ready      = 1'b0;
    dc_rd         = '0;
    dc_ready      = 1'b0;
    case (r_state)
      GRANT_I: begin
        mem_addr      = ic_addr;
        mem_wr        = ic_wr;
        mem_rw        = ic_rw;
        mem_valid_out = ic_valid;
        ic_rd         = mem_rd;
        ic_ready      = mem_ready;
      end
      GRANT_D: begin
        mem_addr      = dc_addr;
        mem_wr        = dc_wr;
        mem_rw        = dc_rw;
        mem_valid_out = dc_valid;
        dc_rd         = mem_rd;
        dc_ready      = mem_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed boundary cases, then two random requesters
// against a random-latency memory, checked by a scoreboard monitor.
module tb_cache_mem_arbiter;

  localparam int AW = 28;
  localparam int BS = 256;
`ifdef ARB_DCACHE_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req_valid [2];
  logic          req_rw    [2];
  logic [AW-1:0] req_addr  [2];
  logic [BS-1:0] req_wr    [2];
  logic [BS-1:0] ic_rd, dc_rd, mem_wr, mem_rd;
  logic          ic_ready, dc_ready, mem_rw, mem_valid_out, mem_ready;
  logic [AW-1:0] mem_addr;
  logic          auto_mode, auto_ready, man_ready, mon_en;
  logic [BS-1:0] auto_rd, man_rd;

  assign mem_ready = auto_mode ? auto_ready : man_ready;
  assign mem_rd    = auto_mode ? auto_rd : man_rd;

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_addr(req_addr[0]), .ic_wr(req_wr[0]), .ic_rw(req_rw[0]), .ic_valid(req_valid[0]),
    .ic_rd(ic_rd), .ic_ready(ic_ready),
    .dc_addr(req_addr[1]), .dc_wr(req_wr[1]), .dc_rw(req_rw[1]), .dc_valid(req_valid[1]),
    .dc_rd(dc_rd), .dc_ready(dc_ready),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rw(mem_rw), .mem_valid_out(mem_valid_out),
    .mem_rd(mem_rd), .mem_ready(mem_ready)
  );

  typedef struct {
    bit            rw;
    logic [AW-1:0] addr;
    logic [BS-1:0] wdata;
    logic [BS-1:0] rdata;
  } txn_t;

  txn_t          q0[$];
  txn_t          q1[$];
  logic [BS-1:0] ref_mem   [bit [AW-1:0]];
  logic [BS-1:0] mem_store [bit [AW-1:0]];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BS-1:0] dflt(input logic [AW-1:0] a);
    return {8{4'h5, a}};
  endfunction

  function automatic logic [BS-1:0] rand_line();
    logic [BS-1:0] v;
    for (int k = 0; k < BS / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Memory side: random 0..3 wait cycles, then one ready pulse.
  initial begin : mem_resp
    bit busy;
    int remain;
    busy = 1'b0;
    remain = 0;
    auto_ready = 1'b0;
    auto_rd = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!auto_mode || !mem_valid_out) begin
        busy = 1'b0;
        auto_ready = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          remain = $urandom_range(0, 3);
        end
        if (remain == 0) begin
          auto_ready = 1'b1;
          if (mem_rw) begin
            mem_store[mem_addr] = mem_wr;
            auto_rd = rand_line();
          end else begin
            auto_rd = mem_store.exists(mem_addr) ? mem_store[mem_addr] : dflt(mem_addr);
          end
        end else begin
          remain--;
          auto_ready = 1'b0;
        end
      end
    end
  end

  // Random requester: one outstanding request at a time, expected result queued on issue.
  task automatic run_req(input int id, input int n);
    txn_t       e;
    int         gap;
    int         k;
    logic [3:0] a4;
    for (int t = 0; t < n; t++) begin
      gap = $urandom_range(0, 2);
      req_valid[id] = 1'b0;
      repeat (gap) tick();
      a4 = 4'($urandom_range(0, 15));
      e.rw = ($urandom_range(0, 2) == 0);
      e.addr = {id[0], 23'd0, a4};
      e.wdata = rand_line();
      if (e.rw) begin
        ref_mem[e.addr] = e.wdata;
        e.rdata = '0;
      end else begin
        e.rdata = ref_mem.exists(e.addr) ? ref_mem[e.addr] : dflt(e.addr);
      end
      if (id == 1) q1.push_back(e);
      else q0.push_back(e);
      req_addr[id]  = e.addr;
      req_rw[id]    = e.rw;
      req_wr[id]    = e.wdata;
      req_valid[id] = 1'b1;
      k = 0;
      do begin
        smp();
        k++;
      end while (!((id == 1) ? dc_ready : ic_ready) && k < 100);
      if (k >= 100) check("req_timeout", 1'b0, 1'b1);
      tick();
      req_valid[id] = 1'b0;
    end
  endtask

  // Scoreboard monitor: arbitration order, grant latency and every completed transaction.
  initial begin : monitor
    bit   pv, pi, pd, last, exp_o, have;
    int   gcyc, id;
    txn_t e;
    pv = 0; pi = 0; pd = 0; last = 0; gcyc = 0;
    forever begin
      smp();
      if (!mon_en) begin
        pv = 0; pi = 0; pd = 0; last = 0; gcyc = 0;
      end else begin
        if (!pv && (pi || pd)) begin
          exp_o = (pi && pd) ? (PRIO ? 1'b1 : !last) : pd;
          check("grant_latency", mem_valid_out, 1'b1);
          check("grant_owner", mem_addr[AW-1], exp_o);
          last = exp_o;
          gcyc = 0;
        end else if (!pv) begin
          check("idle_quiet", mem_valid_out, 1'b0);
        end
        if (mem_valid_out) gcyc++;
        if (ic_ready || dc_ready) begin
          id = dc_ready ? 1 : 0;
          check("ready_exclusive", ic_ready && dc_ready, 1'b0);
          check("ready_owner", id[0], mem_addr[AW-1]);
          check("other_rd_zero", (id == 1) ? ic_rd : dc_rd, '0);
          have = (id == 1) ? (q1.size() != 0) : (q0.size() != 0);
          check("queue_nonempty", have, 1'b1);
          if (have) begin
            e = (id == 1) ? q1.pop_front() : q0.pop_front();
            check("mem_addr", mem_addr, e.addr);
            check("mem_rw", mem_rw, e.rw);
            if (e.rw) check("mem_wr", mem_wr, e.wdata);
            else check("rd_data", (id == 1) ? dc_rd : ic_rd, e.rdata);
            check("wait_cnt", dut.r_wait_cnt, gcyc - 1);
          end
        end
        pv = mem_valid_out;
        pi = req_valid[0];
        pd = req_valid[1];
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [BS-1:0] pat_a5, pat_1234;
    bit            exp_own;
    int            k;
    pat_a5   = {32{8'hA5}};
    pat_1234 = {16{16'h1234}};
    rst_n = 1'b0; auto_mode = 1'b0; man_ready = 1'b0; man_rd = '0; mon_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_rw[i] = 1'b0; req_addr[i] = '0; req_wr[i] = '0;
    end
    do_reset();

    smp();
    check("rst_mem_valid", mem_valid_out, 1'b0);
    check("rst_readies", {ic_ready, dc_ready}, 2'b00);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_wait_cnt", dut.r_wait_cnt, 16'd0);

    // Single D-cache read with a 3-cycle memory.
    tick();
    req_valid[1] = 1'b1; req_addr[1] = 28'h0000100; req_rw[1] = 1'b0;
    smp(); check("rd_idle_cycle", mem_valid_out, 1'b0);
    tick(); smp();
    check("rd_grant_valid", mem_valid_out, 1'b1);
    check("rd_grant_addr", mem_addr, 28'h0000100);
    check("rd_not_ready", dc_ready, 1'b0);
    tick();
    tick(); man_ready = 1'b1; man_rd = pat_a5;
    smp();
    check("rd_dc_ready", dc_ready, 1'b1);
    check("rd_dc_data", dc_rd, pat_a5);
    check("rd_ic_ready", ic_ready, 1'b0);
    check("rd_wait_cnt", dut.r_wait_cnt, 16'd2);
    tick(); man_ready = 1'b0; req_valid[1] = 1'b0;
    smp();
    check("rd_back_idle", mem_valid_out, 1'b0);
    check("rd_ready_pulse", dc_ready, 1'b0);

    // D-cache writeback.
    tick();
    req_valid[1] = 1'b1; req_addr[1] = 28'h0000200; req_rw[1] = 1'b1; req_wr[1] = pat_1234;
    tick(); smp();
    check("wb_mem_rw", mem_rw, 1'b1);
    check("wb_mem_wr", mem_wr, pat_1234);
    check("wb_ic_quiet", {ic_ready, ic_rd}, '0);
    tick(); man_ready = 1'b1; man_rd = rand_line();
    smp();
    check("wb_dc_ready", dc_ready, 1'b1);
    check("wb_ic_quiet2", {ic_ready, ic_rd}, '0);
    tick(); man_ready = 1'b0; req_valid[1] = 1'b0; req_rw[1] = 1'b0;

    // Both requesters held high, 2-cycle accesses.
    do_reset();
    req_valid[0] = 1'b1; req_addr[0] = 28'h0000010;
    req_valid[1] = 1'b1; req_addr[1] = 28'h8000020;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      smp();
      while (!mem_valid_out && k < 5) begin
        tick(); smp(); k++;
      end
      exp_own = PRIO ? 1'b1 : ((g % 2) == 0);
      check("rr_grant_seen", mem_valid_out, 1'b1);
      check("rr_owner", mem_addr[AW-1], exp_own);
      tick(); man_ready = 1'b1;
      smp();
      check("rr_ready_excl", ic_ready && dc_ready, 1'b0);
      check("rr_owner_ready", exp_own ? dc_ready : ic_ready, 1'b1);
      tick(); man_ready = 1'b0;
    end
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    tick(); tick();

    // Abort of a D grant with an I request pending, then reset in GRANT_I.
    req_valid[1] = 1'b1; req_addr[1] = 28'h0000300;
    tick();
    req_valid[0] = 1'b1; req_addr[0] = 28'h0000040;
    smp();
    check("ab_grant_d", mem_valid_out, 1'b1);
    check("ab_ic_waits", ic_ready, 1'b0);
    tick(); smp(); check("ab_ic_waits2", ic_ready, 1'b0);
    tick(); req_valid[1] = 1'b0;
    smp(); check("ab_valid_drop", mem_valid_out, 1'b0);
    tick(); smp();
    check("ab_idle", mem_valid_out, 1'b0);
    check("ab_idle_ic", ic_ready, 1'b0);
    tick(); smp();
    check("ab_grant_i", mem_valid_out, 1'b1);
    check("ab_grant_i_addr", mem_addr, 28'h0000040);
    check("ab_wait_entry", dut.r_wait_cnt, 16'd0);
    tick(); smp(); check("wc_inc1", dut.r_wait_cnt, 16'd1);
    tick(); rst_n = 1'b0; req_valid[1] = 1'b1; req_addr[1] = 28'h8000050;
    smp(); check("wc_inc2", dut.r_wait_cnt, 16'd2);
    tick(); rst_n = 1'b1;
    smp();
    check("mrst_idle", mem_valid_out, 1'b0);
    check("mrst_wait_cnt", dut.r_wait_cnt, 16'd0);
    check("mrst_ready", {ic_ready, dc_ready}, 2'b00);
    tick(); smp();
    check("mrst_grant_d", mem_addr, 28'h8000050);
    check("mrst_grant_valid", mem_valid_out, 1'b1);
    tick(); man_ready = 1'b1;
    smp(); check("mrst_dc_ready", dc_ready, 1'b1);
    tick(); man_ready = 1'b0; req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    tick();

    // Random traffic from both caches.
    auto_mode = 1'b1;
    do_reset();
    mon_en = 1'b1;
    fork
      run_req(0, 40);
      run_req(1, 40);
    join
    repeat (5) tick();
    check("q_drain", q0.size() + q1.size(), 0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
